// File: rtl/pixel_row_packer.sv
// pixel_row_packer: packs a serial RGB pixel stream into full-row words.
// One assembly buffer is filled pixel by pixel. Each complete row is copied
// into an output register, which holds it until the downstream filter takes it.
// Row position within the frame is tracked, and the first and last rows are flagged.
module pixel_row_packer #(
  parameter int PIX_PER_ROW    = 256,
  parameter int ROWS_PER_FRAME = 256,
  parameter int WIDTH          = 8
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               sync,
  input  logic [3*WIDTH-1:0]                 pix_in,
  input  logic                               pix_valid,
  output logic                               pix_ready,
  output logic [PIX_PER_ROW*WIDTH*3-1:0]     row_out,
  output logic                               row_valid,
  input  logic                               row_ready,
  output logic [$clog2(ROWS_PER_FRAME)-1:0]  row_idx,
  output logic                               sof,
  output logic                               eof,
  output logic                               frame_done
);

  localparam int PIX_W = 3 * WIDTH;
  localparam int ROW_BITS = PIX_PER_ROW * PIX_W;
  localparam int COL_W = $clog2(PIX_PER_ROW);
  localparam int ROW_W = $clog2(ROWS_PER_FRAME);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(PIX_PER_ROW - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS_PER_FRAME - 1);

  typedef enum logic {S_FILL, S_FULL} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_row_cnt;
  logic [PIX_W-1:0]   r_asm [PIX_PER_ROW];
  logic [ROW_BITS-1:0] w_asm_flat;
  logic [ROW_BITS-1:0] r_row_out;
  logic               r_row_valid;
  logic [ROW_W-1:0]   r_row_idx;
  logic               r_frame_done;
  logic               w_load;
  logic               w_pix_ready;
  logic               w_accept;
  logic               w_take;

  assign w_accept = pix_valid && w_pix_ready;
  assign w_take   = r_row_valid && row_ready;

  // The assembly buffer is viewed as one flat row word. Pixel k occupies
  // bits [PIX_W*k +: PIX_W].
  genvar gi;
  generate
    for (gi = 0; gi < PIX_PER_ROW; gi++) begin : g_flat
      assign w_asm_flat[PIX_W*gi +: PIX_W] = r_asm[gi];
    end
  endgenerate

  // Fill FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_FILL;
    else      r_state <= w_state_next;
  end

  // Next state, load decision and pixel-ready; sync overrides everything
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_pix_ready  = 1'b0;
    case (r_state)
      S_FILL: begin
        w_pix_ready = !sync;
        if (sync)
          w_state_next = S_FILL;
        else if (pix_valid && (r_col == LAST_COL))
          w_state_next = S_FULL;
      end
      S_FULL: begin
        // A row moves out when the output register is empty or is being taken.
        // Slot 0 of the next row can then be written in the same cycle.
        w_load      = !sync && (!r_row_valid || row_ready);
        w_pix_ready = w_load;
        if (sync || w_load)
          w_state_next = S_FILL;
      end
      default: w_state_next = S_FILL;
    endcase
  end

  // Column counter; it wraps naturally because PIX_PER_ROW is a power of two
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)          r_col <= '0;
    else if (sync)     r_col <= '0;
    else if (w_accept) r_col <= r_col + 1'b1;
  end

  // Row counter within the frame; it advances when a row is loaded into the output
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)        r_row_cnt <= '0;
    else if (sync)   r_row_cnt <= '0;
    else if (w_load) r_row_cnt <= r_row_cnt + 1'b1;
  end

  // Assembly buffer write. Stale slots are simply overwritten and never cleared.
  always_ff @(posedge CLK) begin
    if (w_accept) r_asm[r_col] <= pix_in;
  end

  // Output register: load a new row, or drop valid once the row has been taken
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_row_out    <= '0;
      r_row_valid  <= 1'b0;
      r_row_idx    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_load) begin
        r_row_out   <= w_asm_flat;
        r_row_valid <= 1'b1;
        r_row_idx   <= r_row_cnt;
      end else if (w_take) begin
        r_row_valid <= 1'b0;
      end
      r_frame_done <= w_take && (r_row_idx == LAST_ROW);
    end
  end

  assign pix_ready  = w_pix_ready;
  assign row_out    = r_row_out;
  assign row_valid  = r_row_valid;
  assign row_idx    = r_row_idx;
  assign frame_done = r_frame_done;
  assign sof        = r_row_valid && (r_row_idx == '0);
  assign eof        = r_row_valid && (r_row_idx == LAST_ROW);

endmodule

// File: tb/tb_pixel_row_packer.sv
// Testbench for pixel_row_packer. It drives random and patterned pixel streams
// and checks every output on every cycle against a row-level reference model.
module tb_pixel_row_packer;

  localparam int PPR = 8;
  localparam int RPF = 4;
  localparam int W   = 8;
  localparam int PW  = 3 * W;
  localparam int RW  = PPR * PW;
  localparam int IW  = $clog2(RPF);

  logic          CLK = 1'b0;
  logic          RST;
  logic          sync;
  logic [PW-1:0] pix_in;
  logic          pix_valid;
  logic          pix_ready;
  logic [RW-1:0] row_out;
  logic          row_valid;
  logic          row_ready;
  logic [IW-1:0] row_idx;
  logic          sof;
  logic          eof;
  logic          frame_done;

  int n_cmp = 0;
  int n_err = 0;

  pixel_row_packer #(.PIX_PER_ROW(PPR), .ROWS_PER_FRAME(RPF), .WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .sync(sync), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .row_out(row_out), .row_valid(row_valid),
    .row_ready(row_ready), .row_idx(row_idx), .sof(sof), .eof(eof),
    .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  // Reference model: a queue of pixels for the partial row, at most one
  // completed row waiting, and the row currently presented downstream.
  logic [PW-1:0] m_cur[$];
  logic [RW-1:0] m_pend;
  bit            m_pend_v;
  logic [RW-1:0] m_out;
  bit            m_out_v;
  int            m_idx;
  int            m_cnt;
  bit            m_fd;
  bit            exp_ready;
  logic [7:0]    pat;

  task automatic check_eq(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] pack_row();
    logic [RW-1:0] r;
    r = '0;
    for (int k = 0; k < PPR; k++) r[PW*k +: PW] = m_cur[k];
    return r;
  endfunction

  task automatic model_reset();
    m_cur.delete();
    m_pend   = '0;
    m_pend_v = 0;
    m_out    = '0;
    m_out_v  = 0;
    m_idx    = 0;
    m_cnt    = 0;
    m_fd     = 0;
  endtask

  task automatic check_outputs();
    exp_ready = !sync && !(m_pend_v && m_out_v && !row_ready);
    check_eq("pix_ready",  RW'(pix_ready),  RW'(exp_ready));
    check_eq("row_valid",  RW'(row_valid),  RW'(m_out_v));
    check_eq("row_out",    row_out,         m_out);
    check_eq("row_idx",    RW'(row_idx),    RW'(m_idx));
    check_eq("sof",        RW'(sof),        RW'(m_out_v && m_idx == 0));
    check_eq("eof",        RW'(eof),        RW'(m_out_v && m_idx == RPF - 1));
    check_eq("frame_done", RW'(frame_done), RW'(m_fd));
  endtask

  // Advance the model across one rising edge using the inputs now applied
  task automatic model_edge();
    bit take, acc, load, fd_next;
    take    = m_out_v && row_ready;
    acc     = pix_valid && exp_ready;
    fd_next = take && (m_idx == RPF - 1);
    if (take) $display("row %0d taken sof=%0b eof=%0b", m_idx, sof, eof);
    if (sync) begin
      m_cur.delete();
      m_pend_v = 0;
      m_cnt    = 0;
      if (take) m_out_v = 0;
    end else begin
      load = m_pend_v && (!m_out_v || row_ready);
      if (load) begin
        m_out    = m_pend;
        m_out_v  = 1;
        m_idx    = m_cnt;
        m_cnt    = (m_cnt + 1) % RPF;
        m_pend_v = 0;
      end else if (take) begin
        m_out_v = 0;
      end
      if (acc) begin
        m_cur.push_back(pix_in);
        if (m_cur.size() == PPR) begin
          m_pend   = pack_row();
          m_pend_v = 1;
          m_cur.delete();
        end
      end
    end
    m_fd = fd_next;
  endtask

  // One clock cycle. The modes are:
  // 0 = patterned stream with ready held high, 1 = random valid/ready,
  // 2 = pixels offered with no row_ready, 3 = random with occasional sync.
  task automatic step(input int mode);
    @(negedge CLK);
    sync = 1'b0;
    case (mode)
      0: begin
        pix_valid = 1'b1;
        row_ready = 1'b1;
        pix_in    = {pat + 8'd2, pat + 8'd1, pat};
      end
      1: begin
        pix_valid = ($urandom_range(0, 3) != 0);
        row_ready = ($urandom_range(0, 2) != 0);
        pix_in    = PW'($urandom);
      end
      2: begin
        pix_valid = 1'b1;
        row_ready = 1'b0;
        pix_in    = PW'($urandom);
      end
      default: begin
        sync      = ($urandom_range(0, 15) == 0);
        pix_valid = ($urandom_range(0, 3) != 0);
        row_ready = sync ? 1'b0 : ($urandom_range(0, 2) != 0);
        pix_in    = PW'($urandom);
      end
    endcase
    #1;
    check_outputs();
    if (mode == 0 && exp_ready) pat = pat + 8'd1;
    model_edge();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST       = 1'b0;
    sync      = 1'b0;
    pix_valid = 1'b0;
    row_ready = 1'b0;
    pix_in    = '0;
    #1;
    model_reset();
    check_outputs();
    @(negedge CLK);
    #1;
    check_outputs();
    RST = 1'b1;
  endtask

  initial begin
    RST       = 1'b0;
    sync      = 1'b0;
    pix_valid = 1'b0;
    row_ready = 1'b0;
    pix_in    = '0;
    pat       = 8'd0;
    model_reset();
    repeat (2) @(posedge CLK);
    do_reset();

    // Partial row, then a reset that must discard it
    repeat (5) step(0);
    do_reset();
    pat = 8'd0;

    // Patterned continuous streaming across two full frames
    repeat (PPR * RPF * 2 + PPR + 3) step(0);

    // Back-pressure: two rows buffered, then a single-cycle take
    repeat (3 * PPR) step(2);
    step(0);
    repeat (PPR + 2) step(2);
    repeat (300) step(1);

    // Random traffic with frame resynchronisation
    repeat (600) step(3);

    // Reset in the middle of traffic, then more random traffic
    repeat (37) step(1);
    do_reset();
    repeat (200) step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_row_packer.md
# pixel_row_packer

Front-end row assembler for the row-parallel image filters. It accepts a serial RGB pixel stream (one 24-bit pixel per handshake) and packs `PIX_PER_ROW` pixels into one `PIX_PER_ROW*WIDTH*3`-bit row word, the format the threshold and window filters consume on their row input. It tracks row position within a frame and flags first and last rows. It is double-buffered, so the next row can be filled while the previous row waits for the downstream filter.

## Interface
- `PIX_PER_ROW`, 256: pixels per row; power of two, at least 2.
- `ROWS_PER_FRAME`, 256: rows per frame; power of two, at least 2.
- `WIDTH`, 8: bits per colour channel.
- `CLK` in 1: single clock; all state updates on rising edge.
- `RST` in 1: reset, asynchronous and active-low.
- `sync` in 1: frame resynchronise, active-high, single-cycle.
- `pix_in` in `3*WIDTH`: pixel with R=[7:0], G=[15:8], B=[23:16] at WIDTH=8.
- `pix_valid` in 1: `pix_in` is valid.
- `pix_ready` out 1: packer accepts pixel this cycle.
- `row_out` out `PIX_PER_ROW*WIDTH*3`: assembled row. Pixel k sits at `[3*WIDTH*k +: 3*WIDTH]`, in the same channel order as `pix_in`.
- `row_valid` out 1: `row_out` is valid.
- `row_ready` in 1: downstream takes the row this cycle.
- `row_idx` out clog2(`ROWS_PER_FRAME`): row number of `row_out` within the frame.
- `sof` out 1: high while `row_valid` is high and `row_idx`==0.
- `eof` out 1: high while `row_valid` is high and `row_idx`==`ROWS_PER_FRAME`-1.
- `frame_done` out 1: one-cycle pulse on the cycle after the eof row handshake.

## Operation
- Pixel handshake: a pixel is accepted on a rising edge where `pix_valid`&&`pix_ready`. A row is taken on an edge where `row_valid`&&`row_ready`.
- Assembly buffer `asm`, column counter `col` (clog2 `PIX_PER_ROW` bits), and fill FSM:
  - FILL: each accepted pixel is written to `asm` slot `col`, and `col` increments.
  - Accepting a pixel with `col`==`PIX_PER_ROW`-1 wraps `col` to 0 and moves the FSM to FULL.
  - FULL: `asm` holds a complete row. `load` = FULL && (!`row_valid` || `row_ready`). On `load`, `asm` is copied to `row_out`, `row_valid` is set to 1, `row_idx` takes `row_cnt`, `row_cnt` increments (wrapping at `ROWS_PER_FRAME`), and the FSM returns to FILL.
- `pix_ready` = (FILL || `load`) && !`sync`. Combinational, with no path from `pix_valid`.
- In FULL with `load` true, a pixel may be accepted into slot 0 in the same cycle; the copy uses the pre-edge `asm`. This gives zero-bubble throughput.
- `row_valid` stays high, and `row_out`/`row_idx` stay stable, until the row handshake. It clears on a handshake without a simultaneous `load`. A handshake together with `load` keeps `row_valid` at 1 with the new row.
- `sof` and `eof` are combinational from `row_valid` and `row_idx`.
- `sync` has priority over everything else:
  - `col`←0, `row_cnt`←0, FSM←FILL.
  - The partial or complete row in `asm` is discarded; no pixel is accepted that cycle.
  - The output register, `row_valid` and `row_idx` are untouched.
- Unused `asm` slots are never cleared. Only complete rows ever reach `row_out`.

## Timing
- Reset (`RST`=0, immediate): `row_out`=0, `row_valid`=0, `row_idx`=0, `frame_done`=0, `col`=0, `row_cnt`=0, FSM=FILL. Outputs then read `pix_ready`=1 (unless `sync`), `sof`=0, `eof`=0.
- Reset mid-row or mid-frame discards all data. The first pixel after `RST` rises lands in slot 0 of row 0.
- Latency: if the last pixel of a row is accepted on edge N and the output is free, `row_valid` rises after edge N+1.
- Back-pressure: if `row_ready`=0 while `row_valid`=1 and `asm` is FULL, `pix_ready`=0 until the edge that takes the row. At most two rows are buffered.
- `frame_done` is high for exactly the cycle after the edge that hands off the `eof` row; otherwise it is 0.
- Sustained rate: 1 pixel per clock, and 1 row per `PIX_PER_ROW` clocks with `row_ready`=1.

## Test plan
- Reset/idle: hold `RST`=0, then release → all outputs at reset values and `pix_ready`=1. Drop `RST` to 0 after 100 pixels, then send 256 pixels → the row holds exactly those 256 with `row_idx`=0.
- Packing order: stream pixel k = {B=k+2, G=k+1, R=k} (8-bit wrap), `row_ready`=1 → `row_out[24k+:8]`=k, `[24k+8+:8]`=k+1, `[24k+16+:8]`=k+2 for all k. `row_valid` rises one edge after pixel 255 and `sof`=1.
- Full frame with continuous streaming: 65536 pixels, `pix_valid`=`row_ready`=1 → no `pix_ready` gap after reset, and 256 rows with `row_idx` 0..255. `eof` falls on row 255 only, `frame_done` is one pulse, and the next row has `row_idx`=0 and `sof`=1.
- Back-pressure: `row_ready`=0 while sending 512 pixels → after row 1 fills, `pix_ready`=0 and row 0 stays held. Raise `row_ready` for one cycle → row 1 loads the same edge and `pix_ready`=1 again.
- Sync mid-row: send 100 pixels, then pulse `sync` with `pix_valid`=1 → that pixel is dropped. The next 256 pixels form a row with `row_idx`=0, and the earlier held output row is unchanged.
- Simultaneous load, take and accept: FULL with `row_valid`=1, `row_ready`=1 and `pix_valid`=1 in one cycle → the new row replaces the old, `row_valid` stays 1, and the pixel lands in slot 0 of the next row.
